hazard_stall_unit: RTL and testbench

//  Consumer-side hazard control for the 5-stage RV32I pipeline. It complements operand forwarding, which resolves
//  MEM/WB-produced operands in EX. This unit covers the cases forwarding cannot: load-use dependences seen in ID,

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_stall_unit.sv | 138 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for pipeline hazard control: FSM state, register constants, stall-control bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_pkg;

  // Hazard FSM: normal flow, or counting out extra load-use bubbles
  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  // x0 is hard-wired zero, so it never creates a true dependence
  localparam logic [4:0] REG_X0 = 5'd0;

  // Per-stage stall/flush/bubble controls, shared with the pipeline-register wrappers
  typedef struct packed {
    logic pcStall;
    logic IFID_stall;
    logic IFID_flush;
    logic IDEX_stall;
    logic IDEX_bubble;
    logic EXMEM_stall;
    logic MEMWB_bubble;
  } stall_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the source operands in ID.
// Latency: zero (pure combinational).
// Backpressure: none; the result is consumed by the hazard FSM.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1Addr_i,
  input  logic [4:0] rs2Addr_i,
  input  logic       useRs1_i,
  input  logic       useRs2_i,
  input  logic [4:0] rdAddr_i,
  input  logic       memRead_i,
  output logic       luHaz_o
);

  logic rs1_match;
  logic rs2_match;

  // A dependence exists only for operands the ID instruction actually reads
  assign rs1_match = useRs1_i && (rdAddr_i == rs1Addr_i);
  assign rs2_match = useRs2_i && (rdAddr_i == rs2Addr_i);
  assign luHaz_o   = memRead_i && (rdAddr_i != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use bubbles, EX redirect flush, data-memory wait freeze, perf/timeout tracking.
// Latency: control outputs are combinational (zero cycles); state and counters update on posedge clk.
// Backpressure: memory wait freezes PC..EX/MEM and bubbles MEM/WB; load-use holds PC and IF/ID and bubbles ID/EX.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter int unsigned PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ID_rs1Addr,
  input  logic [4:0]        ID_rs2Addr,
  input  logic              ID_useRs1,
  input  logic              ID_useRs2,
  input  logic [4:0]        EX_rdAddr,
  input  logic              EX_memRead,
  input  logic              EX_redirect,
  input  logic              MEM_memReq,
  input  logic              MEM_memReady,
  output logic              pcStall,
  output logic              IFID_stall,
  output logic              IFID_flush,
  output logic              IDEX_stall,
  output logic              IDEX_bubble,
  output logic              EXMEM_stall,
  output logic              MEMWB_bubble,
  output logic              memTimeout,
  output logic [PERF_W-1:0] stallCycles
);

  // Entering LU_STALL already accounts for the first bubble issued from RUN
  localparam logic [2:0] LU_INIT    = 3'(LOAD_USE_STALLS - 1);
  localparam logic [7:0] TIMEOUT_TH = 8'(MEM_TIMEOUT);

  hz_state_e         state_q, state_d;
  logic [2:0]        luCnt_q, luCnt_d;
  logic [7:0]        waitCnt_q, waitCnt_d;
  logic              memTimeout_q, memTimeout_d;
  logic [PERF_W-1:0] stallCycles_q, stallCycles_d;

  logic        luHaz;
  logic        memWait;
  stall_ctrl_t ctrl;

  load_use_detect u_load_use_detect (
    .rs1Addr_i (ID_rs1Addr),
    .rs2Addr_i (ID_rs2Addr),
    .useRs1_i  (ID_useRs1),
    .useRs2_i  (ID_useRs2),
    .rdAddr_i  (EX_rdAddr),
    .memRead_i (EX_memRead),
    .luHaz_o   (luHaz)
  );

  assign memWait = MEM_memReq && !MEM_memReady;

  // Prioritised hazard resolution: memory wait, then redirect, then load-use
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    luCnt_d = luCnt_q;
    if (memWait) begin
      // Whole front of the pipe freezes; MEM/WB gets a NOP while the access is outstanding
      ctrl.pcStall      = 1'b1;
      ctrl.IFID_stall   = 1'b1;
      ctrl.IDEX_stall   = 1'b1;
      ctrl.EXMEM_stall  = 1'b1;
      ctrl.MEMWB_bubble = 1'b1;
    end else if (EX_redirect) begin
      // Wrong-path instructions in IF/ID and ID are squashed; any pending load-use bubbles are moot
      ctrl.IFID_flush  = 1'b1;
      ctrl.IDEX_bubble = 1'b1;
      state_d          = RUN;
      luCnt_d          = '0;
    end else if (state_q == LU_STALL) begin
      ctrl.pcStall     = 1'b1;
      ctrl.IFID_stall  = 1'b1;
      ctrl.IDEX_bubble = 1'b1;
      if (luCnt_q <= 3'd1) begin
        state_d = RUN;
        luCnt_d = '0;
      end else begin
        luCnt_d = luCnt_q - 3'd1;
      end
    end else if (luHaz) begin
      ctrl.pcStall     = 1'b1;
      ctrl.IFID_stall  = 1'b1;
      ctrl.IDEX_bubble = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        state_d = LU_STALL;
        luCnt_d = LU_INIT;
      end
    end
  end

  // Wait-cycle counter (saturating), sticky timeout and stall-cycle perf counter
  always_comb begin
    waitCnt_d     = '0;
    if (memWait) begin
      waitCnt_d = (waitCnt_q == 8'hFF) ? waitCnt_q : waitCnt_q + 8'd1;
    end
    memTimeout_d  = memTimeout_q || (memWait && (waitCnt_d >= TIMEOUT_TH));
    stallCycles_d = stallCycles_q + {{(PERF_W-1){1'b0}}, ctrl.pcStall};
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      luCnt_q       <= '0;
      waitCnt_q     <= '0;
      memTimeout_q  <= 1'b0;
      stallCycles_q <= '0;
    end else begin
      state_q       <= state_d;
      luCnt_q       <= luCnt_d;
      waitCnt_q     <= waitCnt_d;
      memTimeout_q  <= memTimeout_d;
      stallCycles_q <= stallCycles_d;
    end
  end

  // Reset gating keeps controls low while reset is held even if inputs show a hazard
  always_comb begin
    pcStall      = rst_n && ctrl.pcStall;
    IFID_stall   = rst_n && ctrl.IFID_stall;
    IFID_flush   = rst_n && ctrl.IFID_flush;
    IDEX_stall   = rst_n && ctrl.IDEX_stall;
    IDEX_bubble  = rst_n && ctrl.IDEX_bubble;
    EXMEM_stall  = rst_n && ctrl.EXMEM_stall;
    MEMWB_bubble = rst_n && ctrl.MEMWB_bubble;
    memTimeout   = memTimeout_q;
    stallCycles  = stallCycles_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one instance with single-bubble load-use, one with three.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_rs1Addr, ID_rs2Addr, EX_rdAddr;
  logic        ID_useRs1, ID_useRs2, EX_memRead, EX_redirect, MEM_memReq, MEM_memReady;

  logic        a_pcStall, a_IFID_stall, a_IFID_flush, a_IDEX_stall, a_IDEX_bubble;
  logic        a_EXMEM_stall, a_MEMWB_bubble, a_memTimeout;
  logic [31:0] a_stallCycles;
  logic        b_pcStall, b_IFID_stall, b_IFID_flush, b_IDEX_stall, b_IDEX_bubble;
  logic        b_EXMEM_stall, b_MEMWB_bubble, b_memTimeout;
  logic [31:0] b_stallCycles;

  int checks = 0;
  int errors = 0;

  // Output vectors: {pcStall, IFID_stall, IFID_flush, IDEX_stall, IDEX_bubble, EXMEM_stall, MEMWB_bubble, memTimeout}
  logic [7:0] o1, o3;
  assign o1 = {a_pcStall, a_IFID_stall, a_IFID_flush, a_IDEX_stall, a_IDEX_bubble,
               a_EXMEM_stall, a_MEMWB_bubble, a_memTimeout};
  assign o3 = {b_pcStall, b_IFID_stall, b_IFID_flush, b_IDEX_stall, b_IDEX_bubble,
               b_EXMEM_stall, b_MEMWB_bubble, b_memTimeout};

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] RD   = 8'b0010_1000;
  localparam logic [7:0] MW   = 8'b1101_0110;

  hazard_stall_unit #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(15), .PERF_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1Addr(ID_rs1Addr), .ID_rs2Addr(ID_rs2Addr), .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
    .EX_rdAddr(EX_rdAddr), .EX_memRead(EX_memRead), .EX_redirect(EX_redirect),
    .MEM_memReq(MEM_memReq), .MEM_memReady(MEM_memReady),
    .pcStall(a_pcStall), .IFID_stall(a_IFID_stall), .IFID_flush(a_IFID_flush),
    .IDEX_stall(a_IDEX_stall), .IDEX_bubble(a_IDEX_bubble), .EXMEM_stall(a_EXMEM_stall),
    .MEMWB_bubble(a_MEMWB_bubble), .memTimeout(a_memTimeout), .stallCycles(a_stallCycles)
  );

  hazard_stall_unit #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(15), .PERF_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1Addr(ID_rs1Addr), .ID_rs2Addr(ID_rs2Addr), .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
    .EX_rdAddr(EX_rdAddr), .EX_memRead(EX_memRead), .EX_redirect(EX_redirect),
    .MEM_memReq(MEM_memReq), .MEM_memReady(MEM_memReady),
    .pcStall(b_pcStall), .IFID_stall(b_IFID_stall), .IFID_flush(b_IFID_flush),
    .IDEX_stall(b_IDEX_stall), .IDEX_bubble(b_IDEX_bubble), .EXMEM_stall(b_EXMEM_stall),
    .MEMWB_bubble(b_MEMWB_bubble), .memTimeout(b_memTimeout), .stallCycles(b_stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge into the input-drive window
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ID_rs1Addr = '0; ID_rs2Addr = '0; ID_useRs1 = 1'b0; ID_useRs2 = 1'b0;
    EX_rdAddr = '0; EX_memRead = 1'b0; EX_redirect = 1'b0;
    MEM_memReq = 1'b0; MEM_memReady = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_load_use_rs1(input logic [4:0] r);
    EX_memRead = 1'b1; EX_rdAddr = r; ID_rs1Addr = r; ID_useRs1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("reset_out1", o1, NONE);
    chk("reset_out3", o3, NONE);
    chk("reset_sc1", a_stallCycles, 0);
    chk("reset_sc3", b_stallCycles, 0);
    tick();
    rst_n = 1'b1;

    // Single-bubble load-use on rs1
    tick();
    set_load_use_rs1(5'd5);
    #1 chk("lu1_stall", o1, LU);
    tick();
    EX_memRead = 1'b0; EX_rdAddr = 5'd0;
    #1 chk("lu1_release", o1, NONE);
    chk("lu1_sc", a_stallCycles, 1);

    // Loads to x0 and unread rs2 never stall; a read rs2 does
    pulse_reset();
    EX_memRead = 1'b1; EX_rdAddr = 5'd0; ID_rs1Addr = 5'd0; ID_useRs1 = 1'b1;
    #1 chk("x0_out1", o1, NONE);
    chk("x0_out3", o3, NONE);
    EX_rdAddr = 5'd7; ID_rs1Addr = 5'd3; ID_rs2Addr = 5'd7; ID_useRs2 = 1'b0;
    #1 chk("rs2_unused", o1, NONE);
    ID_useRs2 = 1'b1;
    #1 chk("rs2_used", o1, LU);

    // Three-bubble load-use from a one-cycle hazard pulse
    pulse_reset();
    tick();
    set_load_use_rs1(5'd5);
    #1 chk("lu3_c1", o3, LU);
    tick();
    clear_inputs();
    #1 chk("lu3_c2", o3, LU);
    tick();
    #1 chk("lu3_c3", o3, LU);
    tick();
    #1 chk("lu3_done", o3, NONE);
    chk("lu3_sc", b_stallCycles, 3);

    // Redirect in the 2nd stall cycle aborts the remaining bubbles
    set_load_use_rs1(5'd9);
    #1 chk("abort_c1", o3, LU);
    tick();
    clear_inputs();
    EX_redirect = 1'b1;
    #1 chk("abort_redirect", o3, RD);
    tick();
    EX_redirect = 1'b0;
    #1 chk("abort_run", o3, NONE);
    chk("abort_sc", b_stallCycles, 4);

    // Async reset while LU_STALL holds luCnt=2
    pulse_reset();
    tick();
    set_load_use_rs1(5'd6);
    tick();
    clear_inputs();
    #1 chk("rst_pre", o3, LU);
    rst_n = 1'b0;
    #1 chk("rst_async_out", o3, NONE);
    chk("rst_async_sc", b_stallCycles, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("rst_post_out", o3, NONE);
    tick();
    #1 chk("rst_post_out2", o3, NONE);
    chk("rst_post_sc", b_stallCycles, 0);

    // Memory wait dominates pending redirect and load-use
    pulse_reset();
    tick();
    MEM_memReq = 1'b1; MEM_memReady = 1'b0; EX_redirect = 1'b1;
    set_load_use_rs1(5'd5);
    for (int i = 0; i < 4; i++) begin
      #1 chk("mw_freeze", o1, MW);
      tick();
    end
    MEM_memReady = 1'b1;
    #1 chk("mw_then_redirect", o1, RD);
    chk("mw_sc", a_stallCycles, 4);
    tick();
    clear_inputs();
    #1 chk("mw_after", o1, NONE);
    chk("mw_sc_after", a_stallCycles, 4);

    // Timeout sets on the 15th consecutive wait cycle and sticks
    pulse_reset();
    MEM_memReq = 1'b1; MEM_memReady = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 14) chk("to_before", a_memTimeout, 0);
      if (i == 15) chk("to_set", a_memTimeout, 1);
    end
    #1 chk("to_wait_out", o1, MW | 8'h01);
    MEM_memReady = 1'b1;
    #1 chk("to_ready_out", o1, 8'h01);
    chk("to_sc", a_stallCycles, 16);
    tick();
    clear_inputs();
    tick();
    chk("to_sticky", a_memTimeout, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
